burst_loopback_slave: RTL and testbench

Downstream burst-side peer of the APB-to-burst bridge. Consumes each outgoing burst (`data_burst_out`/`last`/`db_length`/`db_valid`), buffers it, checks the beat count against the advertised length, and returns the same bytes (optionally XOR-masked) on the bridge's burst-in port (`burst_valid`/`data_burst_in`/`burst_last`). Used as the synthesizable loopback target for APBtoBurst system tests and as a reference burst consumer.

---
 rtl/burst_pkg.sv | 10 +
 rtl/burst_loopback_slave_if.sv | 30 +++
 rtl/burst_fifo.sv | 56 +++++
 rtl/burst_loopback_slave.sv | 145 ++++++++++++++
 tb/tb_burst_loopback_slave.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/burst_pkg.sv
// Shared widths and FSM encoding for the burst loopback slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_pkg;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 9;

    typedef enum logic [1:0] {IDLE, RECV, SEND} lb_state_t;
endpackage

// File: rtl/burst_loopback_slave_if.sv
// Bridge <-> loopback slave burst bus: outgoing beats, return beats, error pulses.
// Latency: n/a (wiring only).
// Backpressure: burst_ready gates outgoing beats, db_ready gates return beats.
interface burst_loopback_slave_if;
    import burst_pkg::*;

    logic              db_valid;
    logic [DATA_W-1:0] data_burst_out;
    logic [LEN_W-1:0]  db_length;
    logic              last;
    logic              burst_ready;
    logic              burst_valid;
    logic [DATA_W-1:0] data_burst_in;
    logic              burst_last;
    logic              db_ready;
    logic              len_err;
    logic              ovf;

    // Bridge side.
    modport master (
        output db_valid, data_burst_out, db_length, last, db_ready,
        input  burst_ready, burst_valid, data_burst_in, burst_last, len_err, ovf
    );

    // Loopback slave side.
    modport slave (
        input  db_valid, data_burst_out, db_length, last, db_ready,
        output burst_ready, burst_valid, data_burst_in, burst_last, len_err, ovf
    );
endinterface

// File: rtl/burst_fifo.sv
// Synchronous DEPTH x DATA_W byte FIFO with occupancy count.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: writes when full and reads when empty are dropped silently.
module burst_fifo
    import burst_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_wr;
    logic              do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_data <= mem[rptr[AW-1:0]];
                rptr    <= rptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/burst_loopback_slave.sv
// Buffers one outgoing burst, checks beat count vs db_length, replays bytes (XOR-masked).
// Latency: first return beat 2 cycles after the last beat is accepted; then 1 beat/cycle.
// Backpressure: burst_ready low while replaying; return beat held stable until db_ready.
module burst_loopback_slave
    import burst_pkg::*;
#(
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] XOR_MASK = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    burst_loopback_slave_if.slave  bus
);
    localparam int               AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(256);

    lb_state_t         state_q;
    lb_state_t         state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic [LEN_W-1:0]  len_cmp;
    logic              ready_q;
    logic              ready_d;
    logic              vld_q;
    logic              vld_d;
    logic              last_q;
    logic              last_d;
    logic              len_err_q;
    logic              len_err_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              wr_en;
    logic              rd_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic [DATA_W-1:0] rd_data;
    logic              beat_acc;
    logic              beat_xfer;

    assign beat_acc  = bus.db_valid && ready_q;
    assign beat_xfer = vld_q && bus.db_ready;

    // Mask is applied on the way in so the return data is a straight flop output.
    burst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (bus.data_burst_out ^ XOR_MASK),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state, counter, error and next-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ready_d   = ready_q;
        vld_d     = vld_q;
        last_d    = last_q;
        len_err_d = 1'b0;
        ovf_d     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        len_cmp   = len_q;
        unique case (state_q)
            IDLE, RECV: begin
                if (beat_acc) begin
                    // First beat of a burst restarts the count and samples the length.
                    if (state_q == IDLE) begin
                        cnt_inc = CNT_W'(1);
                        len_cmp = bus.db_length;
                        len_d   = bus.db_length;
                    end
                    cnt_d = cnt_inc;
                    wr_en = !fifo_full;
                    ovf_d = fifo_full;
                    if (bus.last) begin
                        len_err_d = (cnt_inc != {1'b0, len_cmp});
                        ready_d   = 1'b0;
                        state_d   = SEND;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            SEND: begin
                if (beat_xfer && last_q) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    len_d   = '0;
                    state_d = IDLE;
                end else if ((!vld_q || bus.db_ready) && !fifo_empty) begin
                    // Load the next byte into the output slot when it is empty or draining.
                    rd_en  = 1'b1;
                    vld_d  = 1'b1;
                    last_d = (fifo_count == (AW+1)'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            ready_q   <= 1'b1;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            len_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ready_q   <= ready_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            len_err_q <= len_err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.burst_ready   = ready_q;
    assign bus.burst_valid   = vld_q;
    assign bus.data_burst_in = rd_data;
    assign bus.burst_last    = last_q;
    assign bus.len_err       = len_err_q;
    assign bus.ovf           = ovf_q;
endmodule

// File: tb/tb_burst_loopback_slave.sv
// Bench for burst_loopback_slave: two instances (mask 00 and FF) driven identically.
// Latency: checks return timing and per-beat data against a byte-queue model.
// Backpressure: db_ready held, toggled or randomized on the return path.
module tb_burst_loopback_slave;
    import burst_pkg::*;

    localparam int         DEPTH = 16;
    localparam logic [7:0] MASK1 = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       db_valid = 1'b0;
    logic       last = 1'b0;
    logic       db_ready = 1'b0;
    logic [7:0] dat = 8'h00;
    logic [7:0] len = 8'h00;

    always #5 clk = ~clk;

    burst_loopback_slave_if bus0();
    burst_loopback_slave_if bus1();

    burst_loopback_slave #(.DEPTH(DEPTH), .XOR_MASK(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    burst_loopback_slave #(.DEPTH(DEPTH), .XOR_MASK(MASK1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    assign bus0.db_valid       = db_valid;
    assign bus0.data_burst_out = dat;
    assign bus0.db_length      = len;
    assign bus0.last           = last;
    assign bus0.db_ready       = db_ready;
    assign bus1.db_valid       = db_valid;
    assign bus1.data_burst_out = dat;
    assign bus1.db_length      = len;
    assign bus1.last           = last;
    assign bus1.db_ready       = db_ready;

    logic [1:0] rdy, vld, blast, lerr, ovfs;
    logic [7:0] rdat [2];
    assign rdy     = {bus1.burst_ready, bus0.burst_ready};
    assign vld     = {bus1.burst_valid, bus0.burst_valid};
    assign blast   = {bus1.burst_last,  bus0.burst_last};
    assign lerr    = {bus1.len_err,     bus0.len_err};
    assign ovfs    = {bus1.ovf,         bus0.ovf};
    assign rdat[0] = bus0.data_burst_in;
    assign rdat[1] = bus1.data_burst_in;

    int n_chk = 0;
    int n_fail = 0;

    // Model state for the burst in flight.
    logic [7:0] tx [$];
    logic [7:0] exp_dat [2][32];
    int         exp_n;
    int         rx_n [2];
    int         ovf_seen [2];
    int         lerr_seen [2];
    bit         hold [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score transfers before the edge, stalls and flags after it.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            hold[d] = vld[d] && !db_ready;
            if (vld[d] && db_ready) begin
                if (rx_n[d] < exp_n) begin
                    chk($sformatf("rx_dat%0d_%0d", d, rx_n[d]), rdat[d], exp_dat[d][rx_n[d]]);
                    chk($sformatf("rx_last%0d_%0d", d, rx_n[d]), blast[d], (rx_n[d] == exp_n - 1));
                end else begin
                    chk($sformatf("extra_beat%0d", d), rx_n[d] + 1, exp_n);
                end
                rx_n[d]++;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (ovfs[d]) ovf_seen[d]++;
            if (lerr[d]) lerr_seen[d]++;
            if (hold[d] && rx_n[d] < exp_n) begin
                chk($sformatf("stall_vld%0d", d), vld[d], 1);
                chk($sformatf("stall_dat%0d", d), rdat[d], exp_dat[d][rx_n[d]]);
                chk($sformatf("stall_last%0d", d), blast[d], (rx_n[d] == exp_n - 1));
            end
        end
    endtask

    // Send tx[] as one burst, then collect the return. mode: 0 ready, 1 toggle 1001, 2 random.
    task automatic run_burst(input int n, input logic [7:0] blen, input int mode,
                             input bit junk, input int abort_at);
        int cyc;
        int exp_ovf;
        int exp_lerr;
        exp_n    = (n < DEPTH) ? n : DEPTH;
        exp_ovf  = (n > DEPTH) ? n - DEPTH : 0;
        exp_lerr = (n != int'(blen)) ? 1 : 0;
        for (int i = 0; i < exp_n; i++) begin
            exp_dat[0][i] = tx[i];
            exp_dat[1][i] = tx[i] ^ MASK1;
        end
        for (int d = 0; d < 2; d++) begin
            rx_n[d] = 0; ovf_seen[d] = 0; lerr_seen[d] = 0;
        end
        for (int i = 0; i < n; i++) begin
            db_valid = 1'b1; dat = tx[i]; len = blen; last = (i == n - 1);
            chk("ready_recv", rdy, 2'b11);
            tick();
        end
        db_valid = 1'b0; last = 1'b0;
        chk("ready_drop", rdy, 2'b00);
        chk("len_err_timing", lerr, (exp_lerr != 0) ? 2'b11 : 2'b00);
        tick();
        chk("first_vld", vld, 2'b11);
        cyc = 0;
        while ((rx_n[0] < exp_n || rx_n[1] < exp_n) && cyc < 300 &&
               !(abort_at > 0 && rx_n[0] >= abort_at)) begin
            case (mode)
                0:       db_ready = 1'b1;
                1:       db_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: db_ready = 1'($urandom_range(0, 1));
            endcase
            if (junk) begin
                db_valid = 1'($urandom_range(0, 1));
                dat      = 8'($urandom);
                last     = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        db_valid = 1'b0; last = 1'b0;
        if (abort_at > 0) return;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rx_count%0d", d), rx_n[d], exp_n);
            chk($sformatf("ovf_count%0d", d), ovf_seen[d], exp_ovf);
            chk($sformatf("len_err_count%0d", d), lerr_seen[d], exp_lerr);
        end
        if (mode == 0) chk("b2b_cycles", cyc, exp_n);
        chk("ready_back", rdy, 2'b11);
        chk("vld_done", vld, 2'b00);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, rdy, 2'b11);
        chk({tag, "_vld"}, vld, 2'b00);
        chk({tag, "_last"}, blast, 2'b00);
        chk({tag, "_len_err"}, lerr, 2'b00);
        chk({tag, "_ovf"}, ovfs, 2'b00);
        chk({tag, "_dat0"}, rdat[0], 8'h00);
        chk({tag, "_dat1"}, rdat[1], 8'h00);
    endtask

    initial begin
        int n;
        logic [7:0] blen;
        exp_n = 0;
        rx_n[0] = 0; rx_n[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Directed: basic 4-beat burst (both masks).
        tx = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_burst(4, 8'd4, 0, 1'b0, 0);

        // Short burst against a longer advertised length.
        tx = '{8'h5A, 8'h6B, 8'h7C};
        run_burst(3, 8'd5, 0, 1'b0, 0);

        // Overflow: 20 beats into a 16-byte buffer.
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back(8'(i * 7 + 3));
        run_burst(20, 8'd20, 0, 1'b0, 0);

        // Stalled return path.
        tx = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run_burst(4, 8'd4, 1, 1'b0, 0);

        // Zero length always flags an error.
        tx = '{8'h99, 8'h98};
        run_burst(2, 8'd0, 0, 1'b0, 0);

        // Randomized bursts, junk beats while replaying, idle gaps.
        for (int k = 0; k < 15; k++) begin
            n = $urandom_range(1, 24);
            blen = ($urandom_range(0, 1) != 0) ? 8'(n) : 8'($urandom_range(0, 30));
            tx.delete();
            for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
            run_burst(n, blen, $urandom_range(0, 2), 1'b1, 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset in the middle of the return.
        tx = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_burst(4, 8'd4, 0, 1'b0, 2);
        rst_n = 1'b0;
        #2;
        check_reset_vals("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tx = '{8'hA5};
        run_burst(1, 8'd1, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
